op_n_to_1_pipe: RTL and testbench

OP_N_TO_1_PIPE -- requirements
Module: op_n_to_1_pipe

---
 rtl/op_n_to_1_pipe.sv | 178 +++++++++++++++++
 tb/tb_op_n_to_1_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_n_to_1_pipe.sv
// op_n_to_1_pipe: sums OP_NUM masked operands through a pipelined 3:2 carry-save tree plus a final adder.
// Latency: ceil(STAGE_NUM/REG_EVERY)+1 cycles from input handshake to out_valid; one transfer per cycle.
// Backpressure: one valid bit per rank; a rank loads when it is empty or the rank after it advances.
// Ports: axis_clk / axis_rst_n (async, active-low); in_op, in_mask, in_last with in_valid/in_ready;
//        out_sum, out_last with out_valid/out_ready.
module op_n_to_1_pipe #(
  parameter int OP_NUM    = 16,
  parameter int OP_WIDTH  = 32,
  parameter int SIGNED    = 1,
  parameter int REG_EVERY = 1,
  localparam int OUT_WIDTH = OP_WIDTH + $clog2(OP_NUM)
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst_n,
  input  logic [OP_WIDTH-1:0]  in_op [OP_NUM-1:0],
  input  logic [OP_NUM-1:0]    in_mask,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_sum,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Operand count after one 3:2 stage.
  function automatic int next_n(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  // Operand count entering stage s.
  function automatic int lvl_n(input int s);
    int n;
    n = OP_NUM;
    for (int i = 0; i < s; i++) n = next_n(n);
    return n;
  endfunction

  // All tree levels are packed back to back in one array; this is where level s starts.
  function automatic int lvl_off(input int s);
    int off;
    off = 0;
    for (int i = 0; i < s; i++) off += lvl_n(i);
    return off;
  endfunction

  function automatic int stage_cnt(input int n0);
    int n;
    int c;
    n = n0;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = next_n(n);
        c++;
      end
    end
    return c;
  endfunction

  localparam int STAGE_NUM = stage_cnt(OP_NUM);

  // A register rank follows stage s every REG_EVERY stages and always after the last stage.
  function automatic bit is_rank(input int s);
    return ((s + 1) % REG_EVERY == 0) || (s == STAGE_NUM - 1);
  endfunction

  // Index of the rank that would follow stage s (number of ranks before it).
  function automatic int rank_of(input int s);
    int r;
    r = 0;
    for (int i = 0; i < s; i++) if (is_rank(i)) r++;
    return r;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] csa_carry(input logic [OUT_WIDTH-1:0] a,
                                                     input logic [OUT_WIDTH-1:0] b,
                                                     input logic [OUT_WIDTH-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  // Carry-save ranks plus the out_sum rank.
  localparam int NR       = rank_of(STAGE_NUM) + 1;
  localparam int LAST_OFF = lvl_off(STAGE_NUM);
  localparam int TOTAL    = LAST_OFF + 2;

  // ---------------------------------------------------------------- flow control
  logic [NR-1:0] rank_vld;
  logic [NR-1:0] rank_last;
  logic [NR-1:0] rank_rdy;
  logic [NR-1:0] rank_ld;
  logic [NR-1:0] src_vld;
  logic [NR-1:0] src_last;

  // Ready ripples back from out_ready; an empty rank is always ready, so bubbles collapse.
  always_comb begin
    logic down_rdy;
    down_rdy = out_ready;
    for (int k = NR - 1; k >= 0; k--) begin
      rank_rdy[k] = !rank_vld[k] || down_rdy;
      down_rdy    = rank_rdy[k];
    end
  end

  always_comb begin
    src_vld[0]  = in_valid;
    src_last[0] = in_last;
    for (int k = 1; k < NR; k++) begin
      src_vld[k]  = rank_vld[k-1];
      src_last[k] = rank_last[k-1];
    end
  end

  assign rank_ld  = rank_rdy & src_vld;
  assign in_ready = rank_rdy[0];

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rank_vld  <= '0;
      rank_last <= '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (rank_rdy[k]) rank_vld[k]  <= src_vld[k];
        if (rank_ld[k])  rank_last[k] <= src_last[k];
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  wire [TOTAL-1:0][OUT_WIDTH-1:0] lvl;

  for (genvar i = 0; i < OP_NUM; i++) begin : g_ext
    logic sgn;
    assign sgn    = (SIGNED != 0) && in_op[i][OP_WIDTH-1];
    assign lvl[i] = in_mask[i] ? {{(OUT_WIDTH - OP_WIDTH){sgn}}, in_op[i]} : '0;
  end

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    localparam int NI = lvl_n(s);
    localparam int NO = lvl_n(s + 1);
    localparam int OI = lvl_off(s);
    localparam int OO = lvl_off(s + 1);
    localparam int G  = NI / 3;

    logic [NO-1:0][OUT_WIDTH-1:0] d;

    // Each triple becomes a sum/carry pair; leftovers pass straight through.
    always_comb begin
      d = '0;
      for (int j = 0; j < G; j++) begin
        d[2*j]   = lvl[OI+3*j] ^ lvl[OI+3*j+1] ^ lvl[OI+3*j+2];
        d[2*j+1] = csa_carry(lvl[OI+3*j], lvl[OI+3*j+1], lvl[OI+3*j+2]);
      end
      for (int j = 0; j < NI % 3; j++) d[2*G+j] = lvl[OI+3*G+j];
    end

    if (is_rank(s)) begin : g_reg
      localparam int RK = rank_of(s);
      logic [NO-1:0][OUT_WIDTH-1:0] q;
      // Load-gated only: junk offered without in_valid never enters the tree state.
      always_ff @(posedge axis_clk) begin
        if (rank_ld[RK]) q <= d;
      end
      assign lvl[OO +: NO] = q;
    end else begin : g_thru
      assign lvl[OO +: NO] = d;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)          out_sum <= '0;
    else if (rank_ld[NR-1])   out_sum <= lvl[LAST_OFF] + lvl[LAST_OFF+1];
  end

  assign out_valid = rank_vld[NR-1];
  assign out_last  = rank_last[NR-1];

endmodule

// File: tb/tb_op_n_to_1_pipe.sv
// tb_op_n_to_1_pipe: directed vectors plus handshake sequences for op_n_to_1_pipe.
// Five instances: 8x8 signed and unsigned (REG_EVERY=1), OP_NUM 2 and 3, and OP_NUM 16 with REG_EVERY=3.
// Inputs change on the falling edge; outputs are sampled 1 time unit after it.
module tb_op_n_to_1_pipe;

  typedef struct {
    logic [7:0][7:0] ops;
    logic [7:0]      mask;
    logic            last;
    int              exp_s;   // 11-bit result of the signed 8x8 instance
    int              exp_u;   // 11-bit result of the unsigned 8x8 instance
  } vec_t;

  typedef struct {
    int   sum;
    logic last;
  } sb_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_last;
  logic            out_ready;
  logic [7:0][7:0] cur_ops;
  logic [7:0]      cur_mask;
  logic [15:0]     mask16;

  logic [7:0] op8  [7:0];
  logic [7:0] op2  [1:0];
  logic [7:0] op3  [2:0];
  logic [7:0] op16 [15:0];

  logic        rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic        ov_a, ov_b, ov_c, ov_d, ov_e;
  logic        last_a, last_b, last_c, last_d, last_e;
  logic [10:0] sum_a, sum_b;
  logic [8:0]  sum_c;
  logic [9:0]  sum_d;
  logic [11:0] sum_e;

  logic [4:0] ov_all, last_all, rdy_all;
  int         sum_all [5];

  int   checks, failures, out_cnt;
  bit   acc_flag;
  sb_t  sb_q [$];
  vec_t vt [9];
  int   cap_lat [5];
  int   cap_sum [5];
  logic cap_last [5];

  always_comb begin
    for (int i = 0; i < 8; i++)  op8[i]  = cur_ops[i];
    for (int i = 0; i < 2; i++)  op2[i]  = cur_ops[i];
    for (int i = 0; i < 3; i++)  op3[i]  = cur_ops[i];
    for (int i = 0; i < 16; i++) op16[i] = cur_ops[i%8];
    mask16 = {cur_mask, cur_mask};
  end

  always_comb begin
    ov_all     = {ov_e, ov_d, ov_c, ov_b, ov_a};
    last_all   = {last_e, last_d, last_c, last_b, last_a};
    rdy_all    = {rdy_e, rdy_d, rdy_c, rdy_b, rdy_a};
    sum_all[0] = int'(sum_a);
    sum_all[1] = int'(sum_b);
    sum_all[2] = int'(sum_c);
    sum_all[3] = int'(sum_d);
    sum_all[4] = int'(sum_e);
  end

  op_n_to_1_pipe #(.OP_NUM(8), .OP_WIDTH(8), .SIGNED(1), .REG_EVERY(1)) dut_a (
    .axis_clk(clk), .axis_rst_n(rst_n), .in_op(op8), .in_mask(cur_mask), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_a), .out_sum(sum_a), .out_last(last_a),
    .out_valid(ov_a), .out_ready(out_ready));

  op_n_to_1_pipe #(.OP_NUM(8), .OP_WIDTH(8), .SIGNED(0), .REG_EVERY(1)) dut_b (
    .axis_clk(clk), .axis_rst_n(rst_n), .in_op(op8), .in_mask(cur_mask), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_b), .out_sum(sum_b), .out_last(last_b),
    .out_valid(ov_b), .out_ready(out_ready));

  op_n_to_1_pipe #(.OP_NUM(2), .OP_WIDTH(8), .SIGNED(1), .REG_EVERY(1)) dut_c (
    .axis_clk(clk), .axis_rst_n(rst_n), .in_op(op2), .in_mask(cur_mask[1:0]), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_c), .out_sum(sum_c), .out_last(last_c),
    .out_valid(ov_c), .out_ready(out_ready));

  op_n_to_1_pipe #(.OP_NUM(3), .OP_WIDTH(8), .SIGNED(1), .REG_EVERY(1)) dut_d (
    .axis_clk(clk), .axis_rst_n(rst_n), .in_op(op3), .in_mask(cur_mask[2:0]), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_d), .out_sum(sum_d), .out_last(last_d),
    .out_valid(ov_d), .out_ready(out_ready));

  op_n_to_1_pipe #(.OP_NUM(16), .OP_WIDTH(8), .SIGNED(1), .REG_EVERY(3)) dut_e (
    .axis_clk(clk), .axis_rst_n(rst_n), .in_op(op16), .in_mask(mask16), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_e), .out_sum(sum_e), .out_last(last_e),
    .out_valid(ov_e), .out_ready(out_ready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Per-instance constants: result width, latency, operand count.
  function automatic int w_of(input int k);
    case (k)
      0, 1:    return 11;
      2:       return 9;
      3:       return 10;
      default: return 12;
    endcase
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0, 1:    return 5;
      2:       return 1;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int n_of(input int k);
    case (k)
      0, 1:    return 8;
      2:       return 2;
      3:       return 3;
      default: return 16;
    endcase
  endfunction

  // Reference: plain integer sum of the enabled operands (operand i is ops[i%8]).
  function automatic int model(input logic [7:0][7:0] o, input logic [7:0] m, input int n, input bit sgn);
    int s;
    s = 0;
    for (int i = 0; i < n; i++)
      if (m[i%8]) s += sgn ? int'($signed(o[i%8])) : int'(o[i%8]);
    return s;
  endfunction

  function automatic int fold(input int v, input int w);
    return v & ((1 << w) - 1);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  // One cycle on the signed 8x8 instance with scoreboard tracking.
  task automatic step(input logic v, input logic [63:0] o, input logic [7:0] m, input logic l, input logic r);
    sb_t e;
    @(negedge clk);
    in_valid  = v;
    cur_ops   = o;
    cur_mask  = m;
    in_last   = l;
    out_ready = r;
    #1;
    if (ov_a && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out got_valid=1 required_valid=0 sum=0x%0h", sum_a);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("out%0d_sum", out_cnt), int'(sum_a), e.sum);
        check($sformatf("out%0d_last", out_cnt), int'(last_a), int'(e.last));
        out_cnt++;
      end
    end
    acc_flag = in_valid && rdy_a;
    if (acc_flag) begin
      e.sum  = fold(model(o, m, 8, 1'b1), 11);
      e.last = l;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() != 0) step(1'b0, 'x, 8'h00, 1'b0, 1'b1);
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    int start_cnt, rdy_low, acc_cnt, held_bad, held_seen, held_sum, stale;
    logic held_last;

    checks   = 0;
    failures = 0;
    out_cnt  = 0;

    vt[0] = '{64'h8080808080808080, 8'hFF, 1'b1, 'h400, 'h400};
    vt[1] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 'h7F8, 'h7F8};
    vt[2] = '{64'hFFFFFFFFFFFFFFFF, 8'h01, 1'b1, 'h7FF, 'h0FF};
    vt[3] = '{64'h7F7F7F7F7F7F7F7F, 8'hFF, 1'b0, 'h3F8, 'h3F8};
    vt[4] = '{64'h0807060504030201, 8'hFF, 1'b1, 'h024, 'h024};
    vt[5] = '{64'h027F8000F010FF01, 8'hFF, 1'b0, 'h001, 'h301};
    vt[6] = '{64'h027F8000F010FF01, 8'h00, 1'b1, 'h000, 'h000};
    vt[7] = '{64'h027F8000F010FF01, 8'hA5, 1'b0, 'h793, 'h093};
    vt[8] = '{64'h8080808080808080, 8'h0F, 1'b1, 'h600, 'h200};

    // Reset state.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    cur_ops   = '0;
    cur_mask  = '0;
    #2;
    check("rst_in_ready_all", int'(rdy_all), 'h1F);
    check("rst_out_valid_all", int'(ov_all), 0);
    check("rst_out_sum_a", int'(sum_a), 0);
    check("rst_out_last_a", int'(last_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_a", int'(rdy_a), 1);

    // Directed table: one isolated transfer per vector, latency and result on every instance.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      cur_ops  = vt[i].ops;
      cur_mask = vt[i].mask;
      in_last  = vt[i].last;
      for (int k = 0; k < 5; k++) begin
        cap_lat[k]  = 0;
        cap_sum[k]  = -1;
        cap_last[k] = 1'bx;
      end
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        if (c == 1) begin
          in_valid = 1'b0;
          cur_ops  = 'x;
        end
        #1;
        for (int k = 0; k < 5; k++) begin
          if (ov_all[k] && cap_lat[k] == 0) begin
            cap_lat[k]  = c;
            cap_sum[k]  = sum_all[k];
            cap_last[k] = last_all[k];
          end
        end
      end
      for (int k = 0; k < 5; k++) begin
        int exp;
        if (k == 0)      exp = vt[i].exp_s;
        else if (k == 1) exp = vt[i].exp_u;
        else             exp = fold(model(vt[i].ops, vt[i].mask, n_of(k), 1'b1), w_of(k));
        check($sformatf("vec%0d_dut%0d_lat", i, k), cap_lat[k], lat_of(k));
        check($sformatf("vec%0d_dut%0d_sum", i, k), cap_sum[k], exp);
        check($sformatf("vec%0d_dut%0d_last", i, k), int'(cap_last[k]), int'(vt[i].last));
      end
    end

    // Throughput: 100 back-to-back transfers, out_ready held high.
    start_cnt = out_cnt;
    rdy_low   = 0;
    for (int c = 0; c < 100; c++) begin
      step(1'b1, {$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      if (!acc_flag) rdy_low++;
    end
    drain();
    check("thru_ready_low_cycles", rdy_low, 0);
    check("thru_out_count", out_cnt - start_cnt, 100);

    // Backpressure: stall the output for 10 cycles while feeding continuously.
    start_cnt = out_cnt;
    acc_cnt   = 0;
    held_bad  = 0;
    held_seen = 0;
    held_sum  = 0;
    held_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, {$urandom, $urandom}, 8'hFF, c[0], 1'b0);
      if (acc_flag) acc_cnt++;
      if (ov_a) begin
        if (held_seen == 0) begin
          held_sum  = int'(sum_a);
          held_last = last_a;
        end else if (int'(sum_a) != held_sum || last_a != held_last) begin
          held_bad++;
        end
        held_seen++;
      end
    end
    check("bp_accepts", acc_cnt, 5);
    check("bp_in_ready_low", int'(rdy_a), 0);
    check("bp_held_cycles", held_seen, 5);
    check("bp_held_changes", held_bad, 0);
    for (int c = 0; c < 10; c++)
      step(1'b1, {$urandom, $urandom}, 8'($urandom_range(0, 255)), c[1], 1'b1);
    drain();
    check("bp_out_count", out_cnt - start_cnt, 15);

    // Reset with three transfers in flight.
    for (int c = 0; c < 3; c++) step(1'b1, {$urandom, $urandom}, 8'hFF, 1'b1, 1'b1);
    check("mid_inflight", sb_q.size(), 3);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_out_valid_all", int'(ov_all), 0);
    check("mid_rst_out_sum_a", int'(sum_a), 0);
    check("mid_rst_out_last_a", int'(last_a), 0);
    check("mid_rst_in_ready_a", int'(rdy_a), 1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready_a", int'(rdy_a), 1);
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 'x, 8'hFF, 1'b0, 1'b1);
      if (ov_a) stale++;
    end
    check("mid_stale_outputs", stale, 0);
    start_cnt = out_cnt;
    step(1'b1, 64'h0807060504030201, 8'hFF, 1'b1, 1'b1);
    drain();
    check("mid_new_out_count", out_cnt - start_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
